// File: rtl/rv_timer_mc_if.sv
// Peripheral register bus shared by the timer/peripheral blocks.
// Read data and error are combinational responses to the strobes.
interface rv_timer_mc_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
);
    logic            reg_we;
    logic            reg_re;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_be;
    logic [DW-1:0]   reg_rdata;
    logic            reg_error;

    modport master (
        output reg_we, reg_re, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_error
    );

    modport slave (
        input  reg_we, reg_re, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_error
    );
endinterface

// File: rtl/rv_timer_mc.sv
// Multi-channel machine timer: one prescaled 64-bit mtime compared against N_TIMERS
// independent one-shot or auto-reload compare channels, each with its own interrupt.
module rv_timer_mc #(
    parameter int unsigned N_TIMERS = 4,
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rv_timer_mc_if.slave        bus,
    output logic [N_TIMERS-1:0] intr_o
);

    logic [AW-1:0] addr_raw;
    logic [15:0]   addr;
    logic [2:0]    glb_idx;
    logic [3:0]    ch_idx;
    logic [1:0]    ch_reg;
    logic          glb_hit, ch_hit, hit, wr;
    logic [DW-1:0] bmask, wm;

    logic                      active_q, active_d;
    logic [11:0]               prescale_q, prescale_d;
    logic [11:0]               pc_q, pc_d;
    logic [7:0]                step_q, step_d;
    logic [63:0]               mtime_q, mtime_d;
    logic [N_TIMERS-1:0]       intr_state_q, intr_state_d;
    logic [N_TIMERS-1:0]       intr_enable_q, intr_enable_d;
    logic [N_TIMERS-1:0]       en_q, en_d, periodic_q, periodic_d;
    logic [N_TIMERS-1:0][63:0] cmp_q, cmp_d;
    logic [N_TIMERS-1:0][31:0] period_q, period_d;
    logic [N_TIMERS-1:0]       expire, test_set;
    logic                      tick;

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] m,
                                            input logic [31:0] w);
        return (old & ~m) | w;
    endfunction

    assign addr_raw = bus.reg_addr;
    assign addr     = 16'(addr_raw);
    assign glb_idx  = addr[4:2];
    assign ch_idx   = addr[7:4];
    assign ch_reg   = addr[3:2];
    // Global block is 0x000..0x018; channels live in 0x100..0x1FF.
    assign glb_hit  = (addr[15:5] == '0) && (glb_idx != 3'd7) && (addr[1:0] == 2'b00);
    assign ch_hit   = (addr[15:8] == 8'h01) && (32'(ch_idx) < N_TIMERS) &&
                      (addr[1:0] == 2'b00);
    assign hit      = glb_hit || ch_hit;
    assign wr       = bus.reg_we && hit;
    assign bus.reg_error = (bus.reg_we || bus.reg_re) && !hit;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < int'(DW / 8); b++) begin
            bmask[8*b +: 8] = {8{bus.reg_be[b]}};
        end
    end
    assign wm = bus.reg_wdata & bmask;

    always_comb begin
        active_d      = active_q;
        prescale_d    = prescale_q;
        step_d        = step_q;
        intr_enable_d = intr_enable_q;
        intr_state_d  = intr_state_q;
        cmp_d         = cmp_q;
        period_d      = period_q;
        en_d          = en_q;
        periodic_d    = periodic_q;
        expire        = '0;
        test_set      = '0;

        tick = active_q && (pc_q == prescale_q);
        pc_d = pc_q;
        if (active_q) begin
            pc_d = tick ? 12'd0 : pc_q + 12'd1;
        end
        mtime_d = tick ? mtime_q + 64'(step_q) : mtime_q;

        if (wr && glb_hit) begin
            case (glb_idx)
                3'd0: active_d = (active_q & ~bmask[0]) | wm[0];
                3'd1: begin
                    prescale_d = (prescale_q & ~bmask[11:0]) | wm[11:0];
                    step_d     = (step_q & ~bmask[23:16]) | wm[23:16];
                end
                3'd2: mtime_d = {mtime_q[63:32], merge32(mtime_q[31:0], bmask, wm)};
                3'd3: mtime_d = {merge32(mtime_q[63:32], bmask, wm), mtime_q[31:0]};
                3'd4: intr_state_d = intr_state_q & ~wm[N_TIMERS-1:0];
                3'd5: intr_enable_d = (intr_enable_q & ~bmask[N_TIMERS-1:0]) |
                                      wm[N_TIMERS-1:0];
                3'd6: test_set = wm[N_TIMERS-1:0];
                default: ;
            endcase
        end

        // Priority per channel: W1C < hw/test set < CMP write clear; CMP write > reload.
        for (int i = 0; i < int'(N_TIMERS); i++) begin
            expire[i] = en_q[i] && (mtime_q >= cmp_q[i]);
            if (expire[i] && periodic_q[i]) begin
                cmp_d[i] = cmp_q[i] + 64'(period_q[i]);
            end
            intr_state_d[i] = intr_state_d[i] | expire[i] | test_set[i];
            if (wr && ch_hit && (ch_idx == 4'(i))) begin
                case (ch_reg)
                    2'd0: begin
                        cmp_d[i] = {cmp_q[i][63:32], merge32(cmp_q[i][31:0], bmask, wm)};
                        intr_state_d[i] = 1'b0;
                    end
                    2'd1: begin
                        cmp_d[i] = {merge32(cmp_q[i][63:32], bmask, wm), cmp_q[i][31:0]};
                        intr_state_d[i] = 1'b0;
                    end
                    2'd2: period_d[i] = merge32(period_q[i], bmask, wm);
                    default: begin
                        en_d[i]       = (en_q[i] & ~bmask[0]) | wm[0];
                        periodic_d[i] = (periodic_q[i] & ~bmask[1]) | wm[1];
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        if (bus.reg_re && glb_hit) begin
            case (glb_idx)
                3'd0:    bus.reg_rdata = {31'd0, active_q};
                3'd1:    bus.reg_rdata = {8'd0, step_q, 4'd0, prescale_q};
                3'd2:    bus.reg_rdata = mtime_q[31:0];
                3'd3:    bus.reg_rdata = mtime_q[63:32];
                3'd4:    bus.reg_rdata = 32'(intr_state_q);
                3'd5:    bus.reg_rdata = 32'(intr_enable_q);
                default: bus.reg_rdata = '0;
            endcase
        end else if (bus.reg_re && ch_hit) begin
            for (int i = 0; i < int'(N_TIMERS); i++) begin
                if (ch_idx == 4'(i)) begin
                    case (ch_reg)
                        2'd0:    bus.reg_rdata = cmp_q[i][31:0];
                        2'd1:    bus.reg_rdata = cmp_q[i][63:32];
                        2'd2:    bus.reg_rdata = period_q[i];
                        default: bus.reg_rdata = {30'd0, periodic_q[i], en_q[i]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q      <= 1'b0;
            prescale_q    <= '0;
            step_q        <= '0;
            pc_q          <= '0;
            mtime_q       <= '0;
            intr_state_q  <= '0;
            intr_enable_q <= '0;
            cmp_q         <= '0;
            period_q      <= '0;
            en_q          <= '0;
            periodic_q    <= '0;
        end else begin
            active_q      <= active_d;
            prescale_q    <= prescale_d;
            step_q        <= step_d;
            pc_q          <= pc_d;
            mtime_q       <= mtime_d;
            intr_state_q  <= intr_state_d;
            intr_enable_q <= intr_enable_d;
            cmp_q         <= cmp_d;
            period_q      <= period_d;
            en_q          <= en_d;
            periodic_q    <= periodic_d;
        end
    end

    assign intr_o = intr_state_q & intr_enable_q;

endmodule
